// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, OPR_sel codes, control-word fields and FSM states
package ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDAC = 4'h1;
    localparam logic [3:0] OP_STAC = 4'h2;
    localparam logic [3:0] OP_INCR = 4'h3;
    localparam logic [3:0] OP_RSTR = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] OPR_NONE  = 3'b000;
    localparam logic [2:0] OPR_WTR   = 3'b001;
    localparam logic [2:0] OPR_INC   = 3'b010;
    localparam logic [2:0] OPR_RESET = 3'b011;
    localparam logic [2:0] OPR_WTA   = 3'b100;

    // Bit positions inside the 9-bit datapath control word
    localparam int CS_OPR_LSB = 6;
    localparam int CS_ALU_LSB = 3;
    localparam int CS_ALU_WE  = 2;
    localparam int CS_AC_WE   = 1;
    localparam int CS_WTA_EN  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC1,
        ST_EXEC2,
        ST_DONE,
        ST_HALT
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op[3] && (op != OP_HALT);
    endfunction

    function automatic logic [8:0] pack_ctrl(input logic [2:0] opr, input logic [2:0] alu,
                                             input logic alu_we, input logic ac_we,
                                             input logic wta);
        logic [8:0] w;
        w = '0;
        w[CS_OPR_LSB +: 3] = opr;
        w[CS_ALU_LSB +: 3] = alu;
        w[CS_ALU_WE]       = alu_we;
        w[CS_AC_WE]        = ac_we;
        w[CS_WTA_EN]       = wta;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - opcode and execute phase to control word, illegal flag
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       exec2,
    output logic [8:0] ctrlsig,
    output logic       illegal,
    output logic       needs_exec2
);

    always_comb begin
        ctrlsig     = '0;
        illegal     = 1'b0;
        needs_exec2 = is_alu_op(opcode);
        if (is_alu_op(opcode)) begin
            // Phase 1 routes the operand through WTA, phase 2 commits the ALU result
            if (exec2) ctrlsig = pack_ctrl(OPR_NONE, opcode[2:0], 1'b1, 1'b0, 1'b0);
            else       ctrlsig = pack_ctrl(OPR_WTA,  opcode[2:0], 1'b0, 1'b0, 1'b1);
        end else begin
            case (opcode)
                OP_NOP, OP_HALT: ctrlsig = '0;
                OP_LDAC: ctrlsig = pack_ctrl(OPR_WTA,   3'b000, 1'b0, 1'b1, 1'b1);
                OP_STAC: ctrlsig = pack_ctrl(OPR_WTR,   3'b000, 1'b0, 1'b0, 1'b0);
                OP_INCR: ctrlsig = pack_ctrl(OPR_INC,   3'b000, 1'b0, 1'b0, 1'b0);
                OP_RSTR: ctrlsig = pack_ctrl(OPR_RESET, 3'b000, 1'b0, 1'b0, 1'b0);
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - fetch/decode/execute FSM driving the datapath control word
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [7:0]       instr,
    output logic             instr_ready,
    output logic [8:0]       ctrlsig,
    output logic [2:0]       dr_out,
    output logic             done,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired_cnt
);

    state_t             state_q, state_d;
    logic [3:0]         ir_q, ir_d;
    logic [2:0]         dr_q, dr_d;
    logic               ready_q, ready_d;
    logic [8:0]         ctrlsig_q, ctrlsig_d;
    logic               done_q, done_d;
    logic               halted_q, halted_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [8:0]         dec_ctrlsig;
    logic               dec_illegal;
    logic               dec_needs_exec2;
    logic               instr_unused;

    assign instr_unused = instr[7];

    ctrl_decode u_decode (
        .opcode      (ir_q),
        .exec2       (state_d == ST_EXEC2),
        .ctrlsig     (dec_ctrlsig),
        .illegal     (dec_illegal),
        .needs_exec2 (dec_needs_exec2)
    );

    // Outputs are computed for the state being entered so they line up with it
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        dr_d     = dr_q;
        halted_d = halted_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid && ready_q) begin
                    ir_d    = instr[6:3];
                    dr_d    = instr[2:0];
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = (ir_q == OP_HALT) ? ST_HALT : ST_EXEC1;
            ST_EXEC1:  state_d = dec_needs_exec2 ? ST_EXEC2 : ST_DONE;
            ST_EXEC2:  state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase

        ready_d   = (state_d == ST_IDLE);
        done_d    = (state_d == ST_DONE);
        ctrlsig_d = ((state_d == ST_EXEC1) || (state_d == ST_EXEC2)) ? dec_ctrlsig : '0;
        if (state_d == ST_HALT) halted_d = 1'b1;
        if ((state_d == ST_EXEC1) && dec_illegal) err_d = 1'b1;
        if (state_d == ST_DONE) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            dr_q      <= '0;
            ready_q   <= 1'b0;
            ctrlsig_q <= '0;
            done_q    <= 1'b0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            dr_q      <= dr_d;
            ready_q   <= ready_d;
            ctrlsig_q <= ctrlsig_d;
            done_q    <= done_d;
            halted_q  <= halted_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign instr_ready = ready_q;
    assign ctrlsig     = ctrlsig_q;
    assign dr_out      = dr_q;
    assign done        = done_q;
    assign halted      = halted_q;
    assign err         = err_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - directed vector bench for ctrl_sequencer
module tb_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic [8:0] ctrlsig;
    logic [2:0] dr_out;
    logic       done;
    logic       halted;
    logic       err;
    logic [7:0] retired_cnt;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_cnt = 8'd0;

    always #5 clk = ~clk;

    ctrl_sequencer #(.CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .ctrlsig     (ctrlsig),
        .dr_out      (dr_out),
        .done        (done),
        .halted      (halted),
        .err         (err),
        .retired_cnt (retired_cnt)
    );

    typedef struct {
        logic [7:0] ins;
        logic [8:0] w1;
        logic [8:0] w2;
        logic       alu;
        logic       e;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_instr(input logic [7:0] ins, input logic [8:0] w1, input logic [8:0] w2,
                             input logic alu, input logic e, input logic full);
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr = ins;
        @(negedge clk);
        instr_valid = 1'b0;
        if (full) begin
            chk("decode_ready", {31'd0, instr_ready}, 32'd0);
            chk("decode_ctrl", {23'd0, ctrlsig}, 32'd0);
            chk("dr_out", {29'd0, dr_out}, {29'd0, ins[2:0]});
        end
        @(negedge clk);
        if (full) begin
            chk("exec1_ctrl", {23'd0, ctrlsig}, {23'd0, w1});
            chk("exec1_done", {31'd0, done}, 32'd0);
        end
        if (alu) begin
            @(negedge clk);
            if (full) chk("exec2_ctrl", {23'd0, ctrlsig}, {23'd0, w2});
        end
        @(negedge clk);
        exp_cnt = exp_cnt + 8'd1;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("retired_cnt", {24'd0, retired_cnt}, {24'd0, exp_cnt});
        if (full) begin
            chk("done_ctrl", {23'd0, ctrlsig}, 32'd0);
            chk("err", {31'd0, err}, {31'd0, e});
            chk("dr_hold", {29'd0, dr_out}, {29'd0, ins[2:0]});
        end
        @(negedge clk);
        if (full) begin
            chk("idle_ready", {31'd0, instr_ready}, 32'd1);
            chk("idle_done", {31'd0, done}, 32'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 8'd0;
    endtask

    initial begin
        int acc[$];
        logic [8:0] words[$];

        vecs[0]  = '{8'h09, 9'b100_000_011, 9'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'h4A, 9'b100_001_001, 9'b000_001_100, 1'b1, 1'b0};
        vecs[2]  = '{8'h10, 9'b001_000_000, 9'b0, 1'b0, 1'b0};
        vecs[3]  = '{8'h18, 9'b010_000_000, 9'b0, 1'b0, 1'b0};
        vecs[4]  = '{8'h23, 9'b011_000_000, 9'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'h05, 9'b000_000_000, 9'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'h70, 9'b100_110_001, 9'b000_110_100, 1'b1, 1'b0};
        vecs[7]  = '{8'h40, 9'b100_000_001, 9'b000_000_100, 1'b1, 1'b0};
        vecs[8]  = '{8'hC1, 9'b100_000_001, 9'b000_000_100, 1'b1, 1'b0};
        vecs[9]  = '{8'h28, 9'b000_000_000, 9'b0, 1'b0, 1'b1};
        vecs[10] = '{8'h3E, 9'b000_000_000, 9'b0, 1'b0, 1'b1};
        vecs[11] = '{8'h09, 9'b100_000_011, 9'b0, 1'b0, 1'b1};

        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 8'h00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, instr_ready}, 32'd0);
        chk("rst_ctrl", {23'd0, ctrlsig}, 32'd0);
        chk("rst_dr", {29'd0, dr_out}, 32'd0);
        chk("rst_flags", {29'd0, done, halted, err}, 32'd0);
        chk("rst_cnt", {24'd0, retired_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);

        for (int i = 0; i < 12; i++)
            run_instr(vecs[i].ins, vecs[i].w1, vecs[i].w2, vecs[i].alu, vecs[i].e, 1'b1);

        // Back-to-back with valid held: INCR r0 then RSTR r3
        do_reset();
        @(negedge clk);
        instr_valid = 1'b1;
        instr = 8'h18;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (ctrlsig != 9'd0) words.push_back(ctrlsig);
            if (instr_ready && instr_valid) acc.push_back(k);
            if (acc.size() == 1 && !instr_ready) instr = 8'h23;
            if (acc.size() == 2 && !instr_ready) instr_valid = 1'b0;
        end
        instr_valid = 1'b0;
        chk("b2b_accepts", acc.size(), 32'd2);
        if (acc.size() == 2) chk("b2b_spacing", acc[1] - acc[0], 32'd4);
        chk("b2b_words", words.size(), 32'd2);
        if (words.size() == 2) begin
            chk("b2b_word0", {23'd0, words[0]}, {23'd0, 9'b010_000_000});
            chk("b2b_word1", {23'd0, words[1]}, {23'd0, 9'b011_000_000});
        end
        chk("b2b_cnt", {24'd0, retired_cnt}, 32'd2);
        chk("b2b_dr", {29'd0, dr_out}, 32'd3);

        // HALT is sticky until reset
        @(negedge clk);
        instr_valid = 1'b1;
        instr = 8'h78;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("halted", {31'd0, halted}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) chk("halt_no_done", {31'd0, done}, 32'd0);
        end
        chk("halt_ready", {31'd0, instr_ready}, 32'd0);
        chk("halt_still", {31'd0, halted}, 32'd1);
        chk("halt_ctrl", {23'd0, ctrlsig}, 32'd0);
        chk("halt_cnt", {24'd0, retired_cnt}, 32'd2);
        do_reset();
        chk("halt_clr", {31'd0, halted}, 32'd0);
        @(negedge clk);
        chk("halt_rst_ready", {31'd0, instr_ready}, 32'd1);

        // Reset during EXEC2 of an ALU op abandons it
        instr_valid = 1'b1;
        instr = 8'h4A;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("abort_exec1", {23'd0, ctrlsig}, {23'd0, 9'b100_001_001});
        @(negedge clk);
        chk("abort_exec2", {23'd0, ctrlsig}, {23'd0, 9'b000_001_100});
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ctrl", {23'd0, ctrlsig}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        chk("abort_cnt", {24'd0, retired_cnt}, 32'd0);
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);

        // 256 NOPs wrap the counter back to zero
        exp_cnt = 8'd0;
        for (int i = 0; i < 256; i++)
            run_instr(8'h00, 9'd0, 9'd0, 1'b0, 1'b0, (i == 0 || i == 255));
        chk("wrap_cnt", {24'd0, retired_cnt}, 32'd0);
        chk("wrap_err", {31'd0, err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
